alu_secuencial: RTL and testbench
=================================

# alu_secuencial

Registered, handshaked successor to the combinational ALU. Parametrised in operand width; it adds a serial multiplier, arithmetic shift and rotate, a carry/borrow flag, and an error flag for illegal codes. All outputs are registered. It sits between the register-file read stage and write-back, and accepts one operation at a time.

## Interface
- BITS, 8: operand and result width (≥ 4).
- FUNC, 4: width of the function code.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valido_in  in  1  request; an operation is accepted on an edge where valido_in && listo.
- funcionALU  in  FUNC  operation code; sampled on accept.
- vectorA  in  BITS  operand A; sampled on accept.
- vectorB  in  BITS  operand B or shift amount; sampled on accept.
- listo  out  1  ready for a new operation; high only in state REPOSO.
- valido_out  out  1  one-cycle pulse; result and flags are fresh.
- resultado  out  BITS  result; held until the next valido_out.
- zero  out  1  resultado == 0.
- overflow  out  1  signed overflow (ADD/SUB); high half non-zero (MUL); otherwise 0.
- carry  out  1  carry-out (ADD); borrow (SUB); last bit shifted out (SHL/SHR/SAR); otherwise 0.
- error  out  1  illegal or compiled-out code.

## Operation
- Codes:
  - 0 ADD.
  - 1 SUB.
  - 2 XOR.
  - 3 AND.
  - 4 OR.
  - 5 MUL: unsigned, low BITS bits of the product.
  - 11 SHL.
  - 12 SHR.
  - 13 SAR: arithmetic right shift.
  - 14 ROL: rotate left.
  - All other codes are illegal.
- ADD/SUB are computed at BITS+1 bits; bit BITS gives carry/borrow.
- ADD overflow: A and B have the same sign and the result sign differs.
- SUB overflow: A and B have different signs and the result sign differs from A.
- Shift amount is vectorB treated as unsigned.
  - SHL/SHR with amount ≥ BITS: result 0; carry 0.
  - SAR with amount ≥ BITS: all bits equal to A[BITS-1]; carry = A[BITS-1].
  - Amount 0: result = A; carry 0.
  - ROL uses amount mod BITS.
- Illegal code: resultado = 0, zero = 1, overflow = 0, carry = 0, error = 1. valido_out still pulses, with latency 1.
- FSM:
  - REPOSO: listo = 1. Accepting a single-cycle op registers the result at the accept edge and stays in REPOSO. Accepting MUL latches the operands, loads the counter with BITS, clears the accumulator, and goes to MULT.
  - MULT: listo = 0. Each edge does one shift-add step and decrements the counter. At the edge where the counter reaches 0, the result is registered, valido_out is set, and the FSM returns to REPOSO.
- valido_in while listo = 0 is ignored; the requester must hold the request.
- flags and resultado change only on edges that set valido_out.

## Timing
- Reset values: listo 1, valido_out 0, resultado 0, zero 1, overflow 0, carry 0, error 0; state REPOSO; counter 0.
- Single-cycle ops: accept at edge E; valido_out high in the cycle after E (latency 1). Back-to-back accepts are allowed every cycle.
- MUL: accept at E; result registered at E+BITS; valido_out high in the cycle after E+BITS. listo is low in cycles E+1 … E+BITS, then high again in the valid cycle.
- rst_n asserted mid-MUL aborts immediately: no valido_out, and all outputs return to their reset values.

## Configuration
- ALU_MUL_EN defined: code 5 is the serial multiplier; state MULT exists.
- ALU_MUL_EN undefined: no multiplier logic. Code 5 is illegal (error = 1, latency 1) and listo is constantly 1 outside reset.

## Structure
- Package alu_pkg holds:
  - operation code constants OP_ADD … OP_ROL;
  - state enum {REPOSO, MULT};
  - the counter width function clog2(BITS+1).
- Sub-module multiplicador_serie holds the accumulator, the shifting multiplicand/multiplier and the counter, with start/done handshake. It is instantiated only under ALU_MUL_EN. The top contains the FSM, the combinational op mux and the flag registers.

## Test plan
- BITS=8, ADD 8'h7F + 8'h01 → valido_out 1 cycle later; resultado 8'h80, overflow 1, carry 0, zero 0.
- SUB 8'h05 − 8'h05 → resultado 0, zero 1, carry 0. SUB 8'h00 − 8'h01 → 8'hFF, carry 1, overflow 0.
- MUL 20 × 20 → listo low 8 cycles; resultado 8'h90, overflow 1. A valido_in during busy is ignored and not executed.
- SAR 8'h80 by 3 → 8'hF0, carry 0. SHL 8'h81 by 9 → 0, carry 0. ROL 8'h81 by 9 → 8'h03.
- Code 7 → resultado 0, zero 1, error 1. Without ALU_MUL_EN, code 5 → error 1 at latency 1.
- rst_n low at cycle 3 of a MUL → all outputs at reset values, no valido_out. A new ADD accepted right after reset completes normally.

Source files
------------

// File: rtl/alu_secuencial_pkg.sv
// alu_pkg: shared operation codes, FSM state type and counter-width helper for alu_secuencial.
package alu_pkg;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_XOR = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;
  localparam int OP_MUL = 5;
  localparam int OP_SHL = 11;
  localparam int OP_SHR = 12;
  localparam int OP_SAR = 13;
  localparam int OP_ROL = 14;
  typedef enum logic {REPOSO, MULT} estado_t;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/alu_secuencial_if.sv
// alu_secuencial_if: request/result bus of alu_secuencial.
//   master drives valido_in/funcionALU/vectorA/vectorB; slave drives listo, valido_out,
//   resultado and the zero/overflow/carry/error flags.
interface alu_secuencial_if #(parameter int BITS = 8, parameter int FUNC = 4);
  logic            valido_in;
  logic [FUNC-1:0] funcionALU;
  logic [BITS-1:0] vectorA;
  logic [BITS-1:0] vectorB;
  logic            listo;
  logic            valido_out;
  logic [BITS-1:0] resultado;
  logic            zero;
  logic            overflow;
  logic            carry;
  logic            error;
  modport master (output valido_in, funcionALU, vectorA, vectorB,
                  input  listo, valido_out, resultado, zero, overflow, carry, error);
  modport slave  (input  valido_in, funcionALU, vectorA, vectorB,
                  output listo, valido_out, resultado, zero, overflow, carry, error);
endinterface

// File: rtl/alu_secuencial_multiplicador_serie.sv
// multiplicador_serie: BITS-step shift-add unsigned multiplier, present only with ALU_MUL_EN.
//   i_start loads i_a/i_b and the step counter; o_done is high during the last step,
//   when o_producto already holds the complete 2*BITS product.
`ifdef ALU_MUL_EN
module multiplicador_serie
  import alu_pkg::*;
#(parameter int BITS = 8) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [BITS-1:0]   i_a,
  input  logic [BITS-1:0]   i_b,
  output logic              o_done,
  output logic [2*BITS-1:0] o_producto
);
  localparam int CW = clog2(BITS + 1);
  logic [2*BITS-1:0] r_acc, r_mcand, w_suma;
  logic [BITS-1:0]   r_mplier;
  logic [CW-1:0]     r_cnt;
  // The sum of the current step is exposed so the top can register it on the final edge.
  assign w_suma     = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done     = r_cnt == CW'(1);
  assign o_producto = w_suma;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{BITS{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= CW'(BITS);
    end else if (r_cnt != '0) begin
      r_acc    <= w_suma;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end
endmodule
`endif

// File: rtl/alu_secuencial.sv
// alu_secuencial: registered, handshaked ALU with flags; serial MUL when ALU_MUL_EN is defined.
//   clk, rst_n (async active-low) plus bus (alu_secuencial_if.slave).
module alu_secuencial
  import alu_pkg::*;
#(parameter int BITS = 8, parameter int FUNC = 4) (
  input logic             clk,
  input logic             rst_n,
  alu_secuencial_if.slave bus
);
  localparam int M = BITS - 1;
  logic [BITS-1:0]   a, b, w_res, w_rot, w_rol;
  logic [BITS:0]     w_add, w_sub, w_shl, w_shr, w_sar;
  logic              w_ovf, w_cy, w_err, w_big, w_listo, w_acepta, w_start, w_simple, w_mul_fin;
  logic [2*BITS-1:0] w_prod;
  int                w_op;
  logic [BITS-1:0]   r_res;
  logic              r_valido, r_zero, r_ovf, r_cy, r_err;
  assign a        = bus.vectorA;
  assign b        = bus.vectorB;
  assign w_op     = int'(bus.funcionALU);
  assign w_acepta = bus.valido_in && w_listo;
  assign w_simple = w_acepta && !w_start;
  assign w_add    = {1'b0, a} + {1'b0, b};
  assign w_sub    = {1'b0, a} - {1'b0, b};
  assign w_big    = b >= BITS'(BITS);
  // Shifts carry one extra bit so the last bit shifted out lands in a fixed position.
  assign w_shl    = {1'b0, a} << b;
  assign w_shr    = {a, 1'b0} >> b;
  assign w_sar    = $signed({a, 1'b0}) >>> b;
  assign w_rot    = b % BITS'(BITS);
  assign w_rol    = (a << w_rot) | (a >> (BITS'(BITS) - w_rot));
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_cy  = 1'b0;
    w_err = 1'b0;
    case (w_op)
      OP_ADD: begin
        {w_cy, w_res} = w_add;
        w_ovf = (a[M] == b[M]) && (w_add[M] != a[M]);
      end
      OP_SUB: begin
        {w_cy, w_res} = w_sub;
        w_ovf = (a[M] != b[M]) && (w_sub[M] != a[M]);
      end
      OP_XOR: w_res = a ^ b;
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_SHL: {w_cy, w_res} = w_big ? '0 : w_shl;
      OP_SHR: {w_res, w_cy} = w_big ? '0 : w_shr;
      OP_SAR: {w_res, w_cy} = w_big ? {(BITS+1){a[M]}} : w_sar;
      OP_ROL: w_res = w_rol;
      default: w_err = 1'b1;
    endcase
  end
`ifdef ALU_MUL_EN
  estado_t r_state, w_next;
  logic    w_done;
  assign w_start   = w_acepta && (w_op == OP_MUL);
  assign w_mul_fin = (r_state == MULT) && w_done;
  multiplicador_serie #(.BITS(BITS)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_a        (a),
    .i_b        (b),
    .o_done     (w_done),
    .o_producto (w_prod)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= REPOSO;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == REPOSO) ? (w_start ? MULT : REPOSO) : (w_done ? REPOSO : MULT);
  end
  always_comb begin
    w_listo = r_state == REPOSO;
  end
`else
  assign w_start   = 1'b0;
  assign w_mul_fin = 1'b0;
  assign w_prod    = '0;
  assign w_listo   = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valido <= 1'b0;
      r_res    <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_cy     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valido <= w_simple || w_mul_fin;
      if (w_simple) begin
        r_res  <= w_res;
        r_zero <= w_res == '0;
        r_ovf  <= w_ovf;
        r_cy   <= w_cy;
        r_err  <= w_err;
      end else if (w_mul_fin) begin
        r_res  <= w_prod[BITS-1:0];
        r_zero <= w_prod[BITS-1:0] == '0;
        r_ovf  <= |w_prod[2*BITS-1:BITS];
        r_cy   <= 1'b0;
        r_err  <= 1'b0;
      end
    end
  end
  assign bus.listo      = w_listo;
  assign bus.valido_out = r_valido;
  assign bus.resultado  = r_res;
  assign bus.zero       = r_zero;
  assign bus.overflow   = r_ovf;
  assign bus.carry      = r_cy;
  assign bus.error      = r_err;
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed plus random checks of alu_secuencial against an arithmetic model.
module tb_alu_secuencial;
  import alu_pkg::*;
  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  alu_secuencial_if #(.BITS(W), .FUNC(4)) bus ();
  alu_secuencial #(.BITS(W), .FUNC(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int sgn(input int v);
    return (v > MASK / 2) ? v - (MASK + 1) : v;
  endfunction
  task automatic model(input int f, a, b, output int res, ovf, cy, err);
    int s;
    res = 0; ovf = 0; cy = 0; err = 0;
    case (f)
      OP_ADD: begin s = a + b; res = s & MASK; cy = s > MASK; s = sgn(a) + sgn(b); ovf = s > MASK / 2 || s < -(MASK / 2) - 1; end
      OP_SUB: begin res = (a - b) & MASK; cy = a < b; s = sgn(a) - sgn(b); ovf = s > MASK / 2 || s < -(MASK / 2) - 1; end
      OP_XOR: res = a ^ b;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_MUL: if (MUL_EN) begin res = (a * b) & MASK; ovf = a * b > MASK; end else err = 1;
      OP_SHL: if (b > 0 && b < W) begin res = (a << b) & MASK; cy = (a >> (W - b)) & 1; end else if (b == 0) res = a;
      OP_SHR: if (b > 0 && b < W) begin res = a >> b; cy = (a >> (b - 1)) & 1; end else if (b == 0) res = a;
      OP_SAR: if (b >= W) begin res = sgn(a) < 0 ? MASK : 0; cy = sgn(a) < 0; end
              else if (b == 0) res = a;
              else begin res = (sgn(a) >>> b) & MASK; cy = (a >> (b - 1)) & 1; end
      OP_ROL: begin s = b % W; res = ((a << s) | (a >> (W - s))) & MASK; end
      default: err = 1;
    endcase
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " listo"}, bus.listo, 1);
    chk({tag, " valido_out"}, bus.valido_out, 0);
    chk({tag, " resultado"}, bus.resultado, 0);
    chk({tag, " zero"}, bus.zero, 1);
    chk({tag, " overflow"}, bus.overflow, 0);
    chk({tag, " carry"}, bus.carry, 0);
    chk({tag, " error"}, bus.error, 0);
  endtask
  task automatic do_op(input int f, a, b);
    int er, eo, ec, ee, lat, cyc;
    string t;
    model(f, a, b, er, eo, ec, ee);
    lat = (f == OP_MUL && MUL_EN) ? W : 0;
    t = $sformatf("op%0d a=%0h b=%0h", f, a, b);
    for (int k = 0; k < 40 && bus.listo !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    bus.funcionALU = 4'(f);
    bus.vectorA = 8'(a);
    bus.vectorB = 8'(b);
    bus.valido_in = 1'b1;
    @(posedge clk); #1;
    bus.valido_in = 1'b0;
    cyc = 0;
    while (bus.valido_out !== 1'b1 && cyc < 40) begin
      chk({t, " busy listo"}, bus.listo, 0);
      @(posedge clk); #1;
      cyc++;
    end
    chk({t, " latency"}, cyc, lat);
    chk({t, " resultado"}, bus.resultado, er);
    chk({t, " zero"}, bus.zero, er == 0);
    chk({t, " overflow"}, bus.overflow, eo);
    chk({t, " carry"}, bus.carry, ec);
    chk({t, " error"}, bus.error, ee);
    chk({t, " listo"}, bus.listo, 1);
  endtask
  initial begin
    int codes[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11, 12, 13, 14, 15};
    bus.valido_in = 1'b0;
    bus.funcionALU = '0;
    bus.vectorA = '0;
    bus.vectorB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(OP_ADD, 'h7F, 'h01);
    chk("add 7F+01 literal", bus.resultado, 'h80);
    @(posedge clk); #1;
    chk("pulse one cycle", bus.valido_out, 0);
    chk("result held", bus.resultado, 'h80);
    chk("flag held", bus.overflow, 1);
    do_op(OP_SUB, 'h05, 'h05);
    do_op(OP_SUB, 'h00, 'h01);
    do_op(OP_SAR, 'h80, 3);
    do_op(OP_SHL, 'h81, 9);
    do_op(OP_ROL, 'h81, 9);
    chk("rol 81 by 9 literal", bus.resultado, 'h03);
    do_op(7, 'h12, 'h34);
    do_op(OP_MUL, 20, 20);
    do_op(OP_SHL, 'h81, 1);
    do_op(OP_SHR, 'h81, 1);
    do_op(OP_SAR, 'h81, 8);
    do_op(OP_SHR, 'hA5, 0);
    do_op(OP_SHL, 'h81, 8);
    do_op(OP_ADD, 'hFF, 'h01);
    do_op(OP_SUB, 'h80, 'h01);
    if (MUL_EN) begin
      bus.funcionALU = 4'(OP_MUL);
      bus.vectorA = 8'd20;
      bus.vectorB = 8'd20;
      bus.valido_in = 1'b1;
      @(posedge clk); #1;
      bus.funcionALU = 4'(OP_ADD);
      bus.vectorA = 8'd1;
      bus.vectorB = 8'd1;
      chk("busy listo 0", bus.listo, 0);
      for (int k = 1; k < W; k++) begin
        @(posedge clk); #1;
        chk($sformatf("busy listo %0d", k), bus.listo, 0);
        chk($sformatf("busy valido %0d", k), bus.valido_out, 0);
      end
      bus.valido_in = 1'b0;
      @(posedge clk); #1;
      chk("mul ignored req valido", bus.valido_out, 1);
      chk("mul ignored req result", bus.resultado, 'h90);
      chk("mul ignored req ovf", bus.overflow, 1);
      @(posedge clk); #1;
      chk("ignored add not run", bus.valido_out, 0);
      chk("ignored add result", bus.resultado, 'h90);
      bus.funcionALU = 4'(OP_MUL);
      bus.vectorA = 8'd200;
      bus.vectorB = 8'd3;
      bus.valido_in = 1'b1;
      @(posedge clk); #1;
      bus.valido_in = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset("mul abort");
      for (int k = 0; k < W + 2; k++) begin
        @(posedge clk); #1;
        chk($sformatf("abort no valido %0d", k), bus.valido_out, 0);
      end
      rst_n = 1'b1;
    end else begin
      do_op(OP_ADD, 'h7F, 'h01);
      rst_n = 1'b0;
      #1;
      chk_reset("async reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    do_op(OP_ADD, 'h33, 'h44);
    for (int i = 0; i < 60; i++) begin
      int f, a, b;
      f = codes[$urandom_range(0, 13)];
      a = int'($urandom_range(0, MASK));
      b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, MASK));
      do_op(f, a, b);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
